spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 52 +++++
 rtl/spi_master.sv | 177 +++++++++++++++++
 tb/tb_spi_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash master.
// - spi_state_e : one-hot FSM state encoding
// - CMD_*       : serial flash opcodes issued by the upstream sequencers
// - SPI_CPOL / MOSI_IDLE : mode-0 idle levels
package spi_pkg;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StLead  = 6'b000010,
        StShift = 6'b000100,
        StDone  = 6'b001000,
        StGap   = 6'b010000,
        StCsh   = 6'b100000
    } spi_state_e;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high
//   clr        : synchronous restart (counter and phase to 0), wins over en
//   tick       : high on the last cycle of each HALF-cycle period
//   phase      : 0 during the first half-period after clr, toggles on each tick
module spi_clk_div #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic phase
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign tick  = en && (cnt_q == LAST);
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-level SPI mode-0 master for serial flash access.
// While trans_req is high, CS stays low and one byte is shifted per latch
// point (MSB first); each received byte is returned with a trans_done pulse.
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   trans_req           : level, keep the sequence open / send another byte
//   tx_din[7:0]         : byte to send, sampled only at latch points
//   rx_dout[7:0]        : last received byte, updated with trans_done
//   trans_done          : one-cycle pulse per completed byte
//   spi_sclk, spi_cs_n  : serial clock (idles low), chip select (active low)
//   spi_mosi, spi_miso  : serial data out / in
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 4,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned CS_HIGH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trans_req,
    input  logic [7:0] tx_din,
    output logic [7:0] rx_dout,
    output logic       trans_done,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int unsigned HALF     = SCLK_DIV / 2;
    localparam int unsigned WAIT_MAX = (GAP_CYC > CS_HIGH) ? GAP_CYC : CS_HIGH;
    localparam int unsigned WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WW-1:0] GAP_LAST = WW'(GAP_CYC - 1);
    localparam logic [WW-1:0] CSH_LAST = WW'(CS_HIGH - 1);

    spi_state_e state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    tx_sr_q, tx_sr_d;  // bits still to send; bit 7 goes straight to MOSI
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic [7:0]    rx_dout_q, rx_dout_d;
    logic          done_q, done_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;

    logic div_en, div_clr, tick, phase;

    assign div_en  = (state_q == StLead) || (state_q == StShift);
    assign div_clr = (state_d != state_q);

    spi_clk_div #(
        .HALF(HALF)
    ) u_clk_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick),
        .phase(phase)
    );

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_dout_q <= '0;
            done_q    <= 1'b0;
            sclk_q    <= SPI_CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= MOSI_IDLE;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_dout_q <= rx_dout_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trans_req) state_d = StLead;
            StLead:  if (tick) state_d = StShift;
            StShift: if (tick && phase && (bit_q == 3'd7)) state_d = StDone;
            StDone:  state_d = StGap;
            StGap:   if (wait_q == GAP_LAST) state_d = trans_req ? StLead : StCsh;
            StCsh:   if (wait_q == CSH_LAST) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        wait_d    = (state_d != state_q) ? '0 : wait_q + 1'b1;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_dout_d = rx_dout_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        unique case (state_q)
            StIdle: begin
                if (trans_req) begin
                    tx_sr_d = tx_din[6:0];
                    mosi_d  = tx_din[7];
                    cs_n_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            StLead: begin
                if (tick) sclk_d = 1'b1;
            end
            StShift: begin
                if (tick) begin
                    if (!phase) begin
                        // End of high phase: falling edge, sample MISO, next MOSI bit.
                        sclk_d  = 1'b0;
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                    end else begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            done_d    = 1'b1;
                            rx_dout_d = rx_sr_q;
                        end else begin
                            sclk_d = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
            end
            StGap: begin
                if (wait_q == GAP_LAST) begin
                    if (trans_req) begin
                        tx_sr_d = tx_din[6:0];
                        mosi_d  = tx_din[7];
                        bit_d   = '0;
                    end else begin
                        cs_n_d = 1'b1;
                        mosi_d = MOSI_IDLE;
                    end
                end
            end
            StCsh: begin
            end
            default: begin
                sclk_d = SPI_CPOL;
                cs_n_d = 1'b1;
                mosi_d = MOSI_IDLE;
            end
        endcase
    end

    assign rx_dout    = rx_dout_q;
    assign trans_done = done_q;
    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       trans_req = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic [7:0] rx_dout;
    logic       trans_done, sclk, cs_n, mosi;
    logic       miso = 1'b0;

    // Second instance at the minimum divider.
    logic       req2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic [7:0] rx2;
    logic       done2, sclk2, cs2_n, mosi2;
    logic       miso2 = 1'b1;

    always #5 clk = ~clk;

    spi_master dut (
        .clk(clk), .rst_n(rst_n), .trans_req(trans_req), .tx_din(tx_din),
        .rx_dout(rx_dout), .trans_done(trans_done), .spi_sclk(sclk),
        .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_master #(.SCLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .trans_req(req2), .tx_din(tx2),
        .rx_dout(rx2), .trans_done(done2), .spi_sclk(sclk2),
        .spi_cs_n(cs2_n), .spi_mosi(mosi2), .spi_miso(miso2)
    );

    // Bytes are right-aligned, first byte in the most significant used slot.
    // exp_last: cycle of the final trans_done; exp_cs_rise: cycle CS goes high.
    typedef struct {
        int          n;
        int          drop_at;
        logic [39:0] tx;
        logic [39:0] miso;
        int          exp_last;
        int          exp_cs_rise;
    } vec_t;

    vec_t tbl[4];
    vec_t cur;

    int n_pass = 0;
    int n_total = 0;

    // Monitor state; cycle 0 is the cycle in which the first byte is latched.
    int          rel, n_done, first_done, last_done, cs_rise, rises, cs_high_open;
    int          midx, mbyte;
    logic [63:0] mosi_cap, rx_cap;
    logic        prev_sclk, prev_cs;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [7:0] miso_byte(input int i);
        logic [39:0] m;
        m = cur.miso;
        if (i >= cur.n) return 8'h00;
        return m[8*(cur.n-1-i) +: 8];
    endfunction

    function automatic logic [7:0] tx_byte(input vec_t v, input int i);
        logic [39:0] t;
        t = v.tx;
        if (i >= v.n) return 8'h00;
        return t[8*(v.n-1-i) +: 8];
    endfunction

    task automatic start_seq(input vec_t v);
        logic [7:0] mb;
        cur = v;
        rel = 0; n_done = 0; first_done = -1; last_done = -1; cs_rise = -1;
        rises = 0; cs_high_open = 0; midx = 0; mbyte = 0;
        mosi_cap = '0; rx_cap = '0;
        prev_sclk = sclk; prev_cs = cs_n;
        mb = miso_byte(0);
        miso = mb[7];
        tx_din = tx_byte(v, 0);
        trans_req = 1'b1;
    endtask

    // Advance to the middle of the next cycle, sample, and update the slave model.
    task automatic step();
        logic [7:0] mb;
        @(negedge clk);
        rel++;
        if (sclk && !prev_sclk) begin
            rises++;
            mosi_cap = {mosi_cap[62:0], mosi};
        end
        if (trans_done) begin
            if (n_done == 0) first_done = rel;
            last_done = rel;
            n_done++;
            rx_cap = {rx_cap[55:0], rx_dout};
        end
        if (cs_n && !prev_cs && cs_rise < 0) cs_rise = rel;
        if (cs_n && n_done < cur.n) cs_high_open++;
        if (!sclk && prev_sclk) begin
            midx++;
            if (midx == 8) begin
                midx = 0;
                mbyte++;
            end
        end
        mb = miso_byte(mbyte);
        miso = mb[7-midx];
        prev_sclk = sclk;
        prev_cs = cs_n;
    endtask

    task automatic run_seq(input string lbl, input vec_t v);
        int upd_at;
        upd_at = -1;
        start_seq(v);
        for (int c = 0; c < 37 * v.n + 20; c++) begin
            step();
            if (trans_done) begin
                if (n_done >= v.n) trans_req = 1'b0;
                else upd_at = rel + 2;
            end
            if (rel == upd_at) tx_din = tx_byte(v, n_done);
            if (rel == v.drop_at) trans_req = 1'b0;
        end
        trans_req = 1'b0;
        chk({lbl, "_done_count"}, 64'(n_done), 64'(v.n));
        chk({lbl, "_first_done"}, 64'(first_done), 64'd35);
        chk({lbl, "_last_done"}, 64'(last_done), 64'(v.exp_last));
        chk({lbl, "_cs_rise"}, 64'(cs_rise), 64'(v.exp_cs_rise));
        chk({lbl, "_sclk_rises"}, 64'(rises), 64'(8 * v.n));
        chk({lbl, "_mosi"}, mosi_cap, 64'(v.tx));
        chk({lbl, "_rx"}, rx_cap, 64'(v.miso));
        chk({lbl, "_cs_high_open"}, 64'(cs_high_open), 64'd0);
    endtask

    initial begin
        int relow, d2, rel2;
        logic [7:0] rx2_got;
        vec_t v;

        // Byte period inside a sequence: DONE + 2 GAP + 2 LEAD + 32 SHIFT = 37 cycles.
        tbl[0] = '{1, -1, {32'h0, CMD_WREN}, 40'hA5, 35, 38};
        tbl[1] = '{5, -1, {CMD_PP, 8'h00, 8'h10, 8'h00, 8'hA5},
                   40'h11_22_33_44_55, 183, 186};
        tbl[2] = '{3, -1, {16'h0, CMD_RDSR, CMD_RDSR, CMD_RDSR}, 40'h03_03_00, 109, 112};
        tbl[3] = '{1, 10, {32'h0, CMD_SE}, 40'h5A, 35, 38};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", 64'(cs_n), 64'd1);
        chk("reset_sclk", 64'(sclk), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd0);
        chk("reset_done", 64'(trans_done), 64'd0);
        chk("reset_rx", 64'(rx_dout), 64'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_seq($sformatf("vec%0d", i), tbl[i]);
        repeat (5) step();

        // Reset in the middle of a byte (rx_dout currently holds 0x5A).
        v = '{1, -1, 40'hFF, 40'h00, 35, 38};
        start_seq(v);
        for (int c = 0; c < 20; c++) step();
        chk("rst_mid_sclk_before", 64'(sclk), 64'd1);
        rst_n = 1'b0;
        trans_req = 1'b0;
        #1;
        chk("rst_mid_cs_n", 64'(cs_n), 64'd1);
        chk("rst_mid_sclk", 64'(sclk), 64'd0);
        chk("rst_mid_mosi", 64'(mosi), 64'd0);
        chk("rst_mid_done", 64'(trans_done), 64'd0);
        chk("rst_mid_rx", 64'(rx_dout), 64'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) step();
        chk("rst_mid_no_done", 64'(n_done), 64'd0);

        run_seq("fresh", '{1, -1, {32'h0, CMD_READ}, 40'hC3, 35, 38});

        // Request re-raised at cycle 39: must wait out CS_HIGH, latch at 46, CS low at 47.
        start_seq('{1, -1, {32'h0, CMD_WREN}, 40'h00, 35, 38});
        relow = -1;
        for (int c = 0; c < 110; c++) begin
            step();
            if (trans_done && n_done == 1) trans_req = 1'b0;
            if (rel == 39) trans_req = 1'b1;
            if (cs_rise > 0 && rel > cs_rise && !cs_n && relow < 0) begin
                relow = rel;
                trans_req = 1'b0;
            end
        end
        trans_req = 1'b0;
        chk("csh_relatch_cs_low", 64'(relow), 64'd47);

        // Minimum divider: 1 + 1 + 16 = 18 cycles to trans_done.
        req2 = 1'b1;
        tx2 = 8'hFF;
        rel2 = 0;
        d2 = -1;
        rx2_got = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rel2++;
            if (done2 && d2 < 0) begin
                d2 = rel2;
                rx2_got = rx2;
                req2 = 1'b0;
            end
        end
        chk("div2_done_cycle", 64'(d2), 64'd18);
        chk("div2_rx", 64'(rx2_got), 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
